// File: rtl/seq_divider.sv
// seq_divider: 4-bit sequential restoring divider with a 3-state FSM.
// The result appears 5 edges after a start is accepted. A zero divisor
// skips iteration and reports div_zero one edge after acceptance.
// Build option: define DIV_SIGNED_EN for two's-complement operands. The
// quotient truncates toward zero and the remainder takes the sign of the
// dividend. Without the option, operands are unsigned and overflow stays 0.
`timescale 1ns/1ps
module seq_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       start,
  output logic [3:0] q,
  output logic [3:0] r,
  output logic       busy,
  output logic       done,
  output logic       div_zero,
  output logic       overflow
);

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  // Control and result registers, cleared by reset
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              zpend_q, zpend_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              dz_q, dz_d;
  logic              ovf_q, ovf_d;

  // Working datapath registers, always reloaded on accept
  logic [DATA_W-1:0] alat_q, dsr_q, dvd_q, prem_q;
  logic              aneg_q, qneg_q, ovfp_q;

  logic              a_neg, b_neg, ovf_acc, accept;
  logic [DATA_W:0]   shift_w, diff_w;
  logic              qbit;
  logic [DATA_W-1:0] prem_nxt, dvd_nxt;

  // Two's-complement negate when neg is set. This is used for the operand
  // magnitudes and for the final sign fix.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x,
                                                 input logic neg);
    return neg ? (~x + DATA_W'(1)) : x;
  endfunction

`ifdef DIV_SIGNED_EN
  assign a_neg   = a[DATA_W-1];
  assign b_neg   = b[DATA_W-1];
  // The most negative dividend over -1 is the only quotient that does not fit
  assign ovf_acc = (a == 4'h8) && (b == 4'hF);
`else
  assign a_neg   = 1'b0;
  assign b_neg   = 1'b0;
  assign ovf_acc = 1'b0;
`endif

  // start is only honoured when nothing is in flight
  assign accept = start && !busy_q && (state_q != CALC);

  // One restoring step. The partial remainder is always below the divisor,
  // so a 5-bit difference keeps a correct sign bit.
  assign shift_w  = {prem_q, dvd_q[DATA_W-1]};
  assign diff_w   = shift_w - {1'b0, dsr_q};
  assign qbit     = ~diff_w[DATA_W];
  assign prem_nxt = qbit ? diff_w[DATA_W-1:0] : shift_w[DATA_W-1:0];
  assign dvd_nxt  = {dvd_q[DATA_W-2:0], qbit};

  // Next-state and result logic for the IDLE/CALC/DONE controller
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    zpend_d = zpend_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (zpend_q) begin
          // A zero divisor was accepted last edge; report it now
          state_d = DONE;
          busy_d  = 1'b0;
          zpend_d = 1'b0;
          quo_d   = 4'hF;
          rem_d   = alat_q;
          dz_d    = 1'b1;
        end else if (accept) begin
          cnt_d  = '0;
          dz_d   = 1'b0;
          ovf_d  = 1'b0;
          busy_d = 1'b1;
          if (b == '0) begin
            zpend_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(3)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          quo_d   = cond_neg(dvd_nxt, qneg_q);
          rem_d   = cond_neg(prem_nxt, aneg_q);
          ovf_d   = ovfp_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      zpend_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      zpend_q <= zpend_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand latch on accept, then the shift/subtract iteration while in CALC
  always_ff @(posedge clk) begin
    if (accept) begin
      alat_q <= a;
      dsr_q  <= cond_neg(b, b_neg);
      dvd_q  <= cond_neg(a, a_neg);
      prem_q <= '0;
      aneg_q <= a_neg;
      qneg_q <= a_neg ^ b_neg;
      ovfp_q <= ovf_acc;
    end else if (state_q == CALC) begin
      prem_q <= prem_nxt;
      dvd_q  <= dvd_nxt;
    end
  end

  assign q        = quo_q;
  assign r        = rem_q;
  assign busy     = busy_q;
  assign done     = (state_q == DONE);
  assign div_zero = dz_q;
  assign overflow = ovf_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock), rst_n input 1 (async active-low reset).
REQ-002 The block SHALL have these ports after clk and rst_n:
  a         input   4  dividend
  b         input   4  divisor
  start     input   1  request a division; sampled on the rising clk edge
  q         output  4  quotient, registered
  r         output  4  remainder, registered
  busy      output  1  high while iterating
  done      output  1  one-cycle pulse, result valid
  div_zero  output  1  last accepted divisor was zero
  overflow  output  1  signed-mode overflow flag
REQ-003 The port list SHALL be identical with and without the configuration macro.

Function
REQ-004 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-005 start SHALL be accepted only in IDLE or DONE, when busy=0. In CALC it SHALL be ignored with no effect on state or outputs.
REQ-006 On accept at edge k with b!=0:
  - latch a and b;
  - clear the 2-bit iteration counter, div_zero and overflow;
  - go to CALC, so busy=1 from edge k.
REQ-007 CALC SHALL perform one restoring step per edge on edges k+1..k+4:
  - shift {partial remainder, dividend} left by 1;
  - trial-subtract the divisor at 5-bit width;
  - if the difference is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-008 At edge k+4 the FSM SHALL load q and r, clear busy, and go to DONE. done SHALL be 1 for exactly the following cycle.
REQ-009 From DONE, the next edge SHALL return the FSM to IDLE unless start is accepted at that edge. q, r, div_zero and overflow SHALL hold until the next accepted start.
REQ-010 Accept-to-done latency SHALL be 5 edges; busy SHALL be high for 4 cycles.
REQ-011 On accept with b==0:
  - do not enter CALC;
  - go directly to DONE at edge k+1;
  - q=4'hF, r=a, div_zero=1.
  busy SHALL stay high for 1 cycle.
REQ-012 Unsigned invariant: a == q*b + r with r < b, for all b != 0.
REQ-013 Changes on a or b after acceptance SHALL NOT affect the result in progress.

Reset
REQ-014 rst_n=0 SHALL, asynchronously and at any time including mid-CALC, force:
  - state to IDLE, counter to 0;
  - q=0, r=0, busy=0, done=0, div_zero=0, overflow=0.
REQ-015 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where it is high.

Configuration
REQ-016 The macro SHALL be DIV_SIGNED_EN.
REQ-017 With DIV_SIGNED_EN defined:
  - a and b are two's complement;
  - the operation uses magnitudes, then fixes signs;
  - the quotient truncates toward zero;
  - the remainder takes the sign of the dividend;
  - latency is unchanged.
REQ-018 With DIV_SIGNED_EN defined, a=4'h8 with b=4'hF (-8/-1) SHALL give q=4'h8, r=0, overflow=1.
REQ-019 With DIV_SIGNED_EN defined, divide-by-zero SHALL follow REQ-011 unchanged.
REQ-020 Without DIV_SIGNED_EN, operands SHALL be unsigned and overflow SHALL be constant 0.

Verification
REQ-021 a=13, b=4, start pulse at edge k -> busy high on edges k..k+4; done=1 in the cycle after edge k+4; q=3, r=1.
REQ-022 a=9, b=0 -> done in the cycle after edge k+1; q=4'hF, r=9, div_zero=1, busy high 1 cycle.
REQ-023 a=15, b=1 accepted, then a=6, b=2, start=1 at edge k+2 -> second start ignored; result q=15, r=0 at the same cycle as REQ-021.
REQ-024 rst_n=0 pulse between edges k+2 and k+3 of a division -> all outputs 0 immediately, no done pulse; a new start after release gives the correct result.
REQ-025 DIV_SIGNED_EN: a=4'h9 (-7), b=2 -> q=4'hD (-3), r=4'hF (-1), overflow=0; a=4'h8, b=4'hF -> q=4'h8, r=0, overflow=1.
REQ-026 Exhaustive sweep of all 256 operand pairs, back-to-back starts issued in DONE -> every result matches REQ-012 (unsigned) or REQ-017 (signed); done occurs once per accepted start.
